dh_shared_key_modexp: RTL and testbench

Receiving-end key derivation for the Diffie-Hellman exchange. The block takes the peer's public value R, this party's private exponent and the prime modulus, and computes the shared secret K = R^private mod p. It uses constant-time right-to-left square-and-multiply, with interleaved shift-add modular multiplication, so no wide multiplier or divider is needed. It sits after the public-value receive path and hands K to the key consumer through a start/done handshake.

---
 rtl/dh_shared_key_modexp_if.sv | 25 ++
 rtl/dh_shared_key_modexp.sv | 136 +++++++++++++
 tb/tb_dh_shared_key_modexp.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dh_shared_key_modexp_if.sv
// Start/done handshake and operand/result bundle for the DH shared-key engine.
// master = requester/key consumer, slave = the modexp engine.
interface dh_shared_key_modexp_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     peer_public;
    logic [EXP_WIDTH-1:0] private_key;
    logic [WIDTH-1:0]     modulus;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     shared_key;
    logic                 error;

    modport master (
        output start, peer_public, private_key, modulus,
        input  busy, done, shared_key, error
    );

    modport slave (
        input  start, peer_public, private_key, modulus,
        output busy, done, shared_key, error
    );
endinterface

// File: rtl/dh_shared_key_modexp.sv
// Constant-time K = R^private mod p: right-to-left square-and-multiply built on
// two interleaved shift-add modular multipliers that share one scan of sq.
module dh_shared_key_modexp #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst,
    dh_shared_key_modexp_if.slave  bus
);
    localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NEXT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_res;
    logic [WIDTH-1:0]     r_sq;
    logic [EXP_WIDTH-1:0] r_e;
    logic [CW-1:0]        r_bit;
    logic [SW-1:0]        r_step;
    logic [WIDTH-1:0]     r_acc1;
    logic [WIDTH-1:0]     r_acc2;
    logic                 r_bad;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [WIDTH-1:0]     r_key;

    logic                 w_invalid;
    logic                 w_scan;
    logic [WIDTH-1:0]     w_nxt1;
    logic [WIDTH-1:0]     w_nxt2;

    // One MSB-first step: acc = 2*acc mod p, then + mcand mod p when the scanned bit is set.
    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] mcand,
        input logic [WIDTH-1:0] p,
        input logic             scan
    );
        logic [WIDTH:0] pe, dbl, red, add, sum;
        pe  = {1'b0, p};
        dbl = {acc, 1'b0};
        red = (dbl >= pe) ? dbl - pe : dbl;
        add = red + {1'b0, mcand};
        sum = (add >= pe) ? add - pe : add;
        return scan ? sum[WIDTH-1:0] : red[WIDTH-1:0];
    endfunction

    always_comb begin
        w_invalid = (bus.modulus < WIDTH'(2)) || (bus.peer_public >= bus.modulus);
        w_scan    = r_sq[r_step];
        w_nxt1    = mm_step(r_acc1, r_res, r_p, w_scan);
        w_nxt2    = mm_step(r_acc2, r_sq,  r_p, w_scan);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_res   <= '0;
            r_sq    <= '0;
            r_e     <= '0;
            r_bit   <= '0;
            r_step  <= '0;
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_bad   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_key   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_p    <= bus.modulus;
                        r_sq   <= bus.peer_public;
                        r_e    <= bus.private_key;
                        r_res  <= WIDTH'(1);
                        r_bit  <= '0;
                        r_step <= SW'(WIDTH - 1);
                        r_acc1 <= '0;
                        r_acc2 <= '0;
                        r_err  <= 1'b0;
                        r_key  <= '0;
                        r_bad  <= w_invalid;
                        r_busy <= ~w_invalid;
                        r_state <= w_invalid ? S_FIN : S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc1 <= w_nxt1;
                    r_acc2 <= w_nxt2;
                    if (r_step == '0) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_step <= r_step - 1'b1;
                    end
                end
                S_NEXT: begin
                    // Product is always computed; only the commit depends on the exponent bit.
                    if (r_e[0]) begin
                        r_res <= r_acc1;
                    end
                    r_sq   <= r_acc2;
                    r_e    <= r_e >> 1;
                    r_bit  <= r_bit + 1'b1;
                    r_acc1 <= '0;
                    r_acc2 <= '0;
                    r_step <= SW'(WIDTH - 1);
                    r_state <= (r_bit == CW'(EXP_WIDTH - 1)) ? S_FIN : S_MUL;
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_err   <= r_bad;
                    r_key   <= r_bad ? '0 : r_res;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_err;
    assign bus.shared_key = r_key;
endmodule

// File: tb/tb_dh_shared_key_modexp.sv
// Scoreboard bench for dh_shared_key_modexp: expected key/error/latency queued
// at issue time, popped and compared when done pulses.
module tb_dh_shared_key_modexp;
    localparam int W   = 32;
    localparam int EW  = 32;
    localparam int LAT = EW * (W + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dh_shared_key_modexp_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus();

    dh_shared_key_modexp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] key;
        logic         err;
        logic         busy;
        logic [31:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [W-1:0] r, input logic [EW-1:0] e, input logic [W-1:0] p);
        exp_t x;
        longint unsigned res, base, pl;
        if (p < 2 || r >= p) begin
            x.key = '0; x.err = 1'b1; x.busy = 1'b0; x.lat = 1;
            return x;
        end
        pl = 64'(p);
        res = 1;
        base = 64'(r);
        for (int i = 0; i < EW; i++) begin
            if (e[i]) res = (res * base) % pl;
            base = (base * base) % pl;
        end
        x.key = res[W-1:0]; x.err = 1'b0; x.busy = 1'b1; x.lat = LAT;
        return x;
    endfunction

    function automatic exp_t fixed(input logic [W-1:0] key);
        exp_t x;
        x.key = key; x.err = 1'b0; x.busy = 1'b1; x.lat = LAT;
        return x;
    endfunction

    task automatic drive(input logic [W-1:0] r, input logic [EW-1:0] e, input logic [W-1:0] p);
        @(negedge clk);
        bus.peer_public = r;
        bus.private_key = e;
        bus.modulus     = p;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output logic [W-1:0] key, output logic err, output int n);
        n = 0; key = '0; err = 1'b0;
        while (n < LAT + 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done === 1'b1) begin
                key = bus.shared_key;
                err = bus.error;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_vec++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b expected 0", bus.error); end
        n_vec++; if (bus.shared_key !== '0) begin n_bad++; $display("FAIL reset_key: got %0h expected 0", bus.shared_key); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_modexp;
        logic [W-1:0]  tr[8];
        logic [EW-1:0] te[8];
        logic [W-1:0]  tp[8];
        logic [W-1:0]  tk[6];
        logic [W-1:0]  key;
        logic          err, b;
        int            n;
        exp_t          x;
        tr[0] = 32'd8; te[0] = 32'd6;          tp[0] = 32'd23;          tk[0] = 32'd13;
        tr[1] = 32'd2; te[1] = 32'd32;         tp[1] = 32'hFFFF_FFFB;   tk[1] = 32'd5;
        tr[2] = 32'd3; te[2] = 32'hFFFF_FFFA;  tp[2] = 32'hFFFF_FFFB;   tk[2] = 32'd1;
        tr[3] = 32'd7; te[3] = 32'd0;          tp[3] = 32'd23;          tk[3] = 32'd1;
        tr[4] = 32'd1; te[4] = 32'hFFFF_FFFF;  tp[4] = 32'd23;          tk[4] = 32'd1;
        tr[5] = 32'd5; te[5] = 32'd3;          tp[5] = 32'd2;           tk[5] = 32'd0;
        for (int i = 6; i < 8; i++) begin
            tp[i] = $urandom | 32'h8000_0001;
            tr[i] = $urandom % tp[i];
            te[i] = $urandom;
        end
        tr[5] = 32'd1;
        tk[5] = 32'd1;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) sb.push_back(fixed(tk[i]));
            else       sb.push_back(model(tr[i], te[i], tp[i]));
            drive(tr[i], te[i], tp[i]);
            b = bus.busy;
            wait_done(key, err, n);
            x = sb.pop_front();
            n_vec++; if (key !== x.key) begin n_bad++; $display("FAIL modexp_key[%0d]: got %0h expected %0h", i, key, x.key); end
            n_vec++; if (err !== x.err) begin n_bad++; $display("FAIL modexp_err[%0d]: got %b expected %b", i, err, x.err); end
            n_vec++; if (n !== int'(x.lat)) begin n_bad++; $display("FAIL modexp_lat[%0d]: got %0d expected %0d", i, n, x.lat); end
            n_vec++; if (b !== x.busy) begin n_bad++; $display("FAIL modexp_busy[%0d]: got %b expected %b", i, b, x.busy); end
        end
    endtask

    task automatic test_error;
        logic [W-1:0]  tr[2];
        logic [W-1:0]  tp[2];
        logic [W-1:0]  key;
        logic          err, b;
        int            n;
        exp_t          x;
        tr[0] = 32'd8;  tp[0] = 32'd1;
        tr[1] = 32'd23; tp[1] = 32'd23;
        for (int i = 0; i < 2; i++) begin
            x.key = '0; x.err = 1'b1; x.busy = 1'b0; x.lat = 1;
            sb.push_back(x);
            drive(tr[i], 32'd5, tp[i]);
            b = bus.busy;
            wait_done(key, err, n);
            x = sb.pop_front();
            n_vec++; if (key !== x.key) begin n_bad++; $display("FAIL error_key[%0d]: got %0h expected %0h", i, key, x.key); end
            n_vec++; if (err !== x.err) begin n_bad++; $display("FAIL error_flag[%0d]: got %b expected %b", i, err, x.err); end
            n_vec++; if (n !== int'(x.lat)) begin n_bad++; $display("FAIL error_lat[%0d]: got %0d expected %0d", i, n, x.lat); end
            n_vec++; if (b !== x.busy) begin n_bad++; $display("FAIL error_busy[%0d]: got %b expected %b", i, b, x.busy); end
        end
    endtask

    task automatic test_ignore_start;
        logic [W-1:0] key;
        logic         err;
        int           n;
        exp_t         x;
        sb.push_back(fixed(32'd13));
        drive(32'd8, 32'd6, 32'd23);
        repeat (99) @(posedge clk);
        @(negedge clk);
        bus.peer_public = 32'd5;
        bus.private_key = 32'd3;
        bus.modulus     = 32'd97;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(key, err, n);
        n = n + 100;
        x = sb.pop_front();
        n_vec++; if (key !== x.key) begin n_bad++; $display("FAIL ignore_key: got %0h expected %0h", key, x.key); end
        n_vec++; if (err !== x.err) begin n_bad++; $display("FAIL ignore_err: got %b expected %b", err, x.err); end
        n_vec++; if (n !== int'(x.lat)) begin n_bad++; $display("FAIL ignore_lat: got %0d expected %0d", n, x.lat); end
    endtask

    task automatic test_mid_reset;
        logic [W-1:0] key;
        logic         err;
        int           n;
        exp_t         x;
        sb.push_back(fixed(32'd13));
        drive(32'd8, 32'd6, 32'd23);
        repeat (499) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        n_vec++; if (bus.shared_key !== '0) begin n_bad++; $display("FAIL midrst_key: got %0h expected 0", bus.shared_key); end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(32'd5, 32'd20, 32'd97));
        drive(32'd5, 32'd20, 32'd97);
        wait_done(key, err, n);
        x = sb.pop_front();
        n_vec++; if (key !== x.key) begin n_bad++; $display("FAIL midrst_fresh_key: got %0h expected %0h", key, x.key); end
        n_vec++; if (n !== int'(x.lat)) begin n_bad++; $display("FAIL midrst_fresh_lat: got %0d expected %0d", n, x.lat); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] key;
        logic         err, b;
        int           n;
        exp_t         x;
        sb.push_back(fixed(32'd13));
        sb.push_back(model(32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFB));
        @(negedge clk);
        bus.peer_public = 32'd8;
        bus.private_key = 32'd6;
        bus.modulus     = 32'd23;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        wait_done(key, err, n);
        x = sb.pop_front();
        n_vec++; if (key !== x.key) begin n_bad++; $display("FAIL b2b_first_key: got %0h expected %0h", key, x.key); end
        n_vec++; if (n !== int'(x.lat)) begin n_bad++; $display("FAIL b2b_first_lat: got %0d expected %0d", n, x.lat); end
        bus.peer_public = 32'h1234_5678;
        bus.private_key = 32'hDEAD_BEEF;
        bus.modulus     = 32'hFFFF_FFFB;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        b = bus.busy;
        wait_done(key, err, n);
        x = sb.pop_front();
        n_vec++; if (b !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b expected 1", b); end
        n_vec++; if (key !== x.key) begin n_bad++; $display("FAIL b2b_second_key: got %0h expected %0h", key, x.key); end
        n_vec++; if (n !== int'(x.lat)) begin n_bad++; $display("FAIL b2b_second_lat: got %0d expected %0d", n, x.lat); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.shared_key !== x.key) begin n_bad++; $display("FAIL b2b_key_hold: got %0h expected %0h", bus.shared_key, x.key); end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.peer_public = '0;
        bus.private_key = '0;
        bus.modulus     = '0;
        test_reset;
        test_modexp;
        test_error;
        test_ignore_start;
        test_mid_reset;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
